instr_fetch: RTL and testbench

//  Instruction fetch stage of the KLP32 core, directly upstream of the control/decode unit.
//  - Owns the PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake.
//  - Presents the fetched word plus its PC to decode with a valid/ready handshake.
//  - Selects the next PC from PCSel and the branch/jump target supplied by the control/ALU path.

---
 rtl/klp32_fetch_pkg.sv | 19 +
 rtl/fetch_pc_gen.sv | 23 ++
 rtl/instr_fetch.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/klp32_fetch_pkg.sv
// Shared definitions for the KLP32 instruction fetch stage: FSM state type,
// the NOP word presented after reset, and the default reset PC.
package klp32_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Byte stride between sequential instructions.
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selector for the KLP32 fetch stage: sequential PC+4 (wrapping
// modulo 2^n) or the control/ALU target with bit 0 cleared.
module fetch_pc_gen
    import klp32_fetch_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [n-1:0] pc,
    input  logic         pc_sel,
    input  logic [n-1:0] target,
    output logic [n-1:0] next_pc
);

    // Pick between the sequential successor and the jump/branch target.
    always_comb begin
        if (pc_sel) begin
            next_pc = target & ~(n'(1));
        end else begin
            next_pc = pc + n'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// KLP32 instruction fetch stage. Owns the PC, issues one instruction memory
// request at a time over req/gnt/rvalid, and hands the fetched word and its
// PC to decode over valid/ready. All outputs are registered.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   - adds instr_misalign; a misaligned PC is not fetched but is
//               presented to decode as a NOP flagged misaligned.
//   undefined - the low two address bits are forced to zero on imem_addr.
module instr_fetch
    import klp32_fetch_pkg::*;
#(
    parameter int          n        = 32,
    parameter logic [n-1:0] RESET_PC = n'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [n-1:0] imem_rdata,
    output logic [n-1:0] instr,
    output logic [n-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         pc_sel,
    input  logic [n-1:0] target
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic         instr_misalign
`endif
);

    localparam logic [n-1:0] ADDR_MASK = ~(n'(3));

    fetch_state_t state;
    fetch_state_t next_state;

    logic [n-1:0] pc;
    logic [n-1:0] pc_next;
    logic [n-1:0] fetch_pc;
    logic         accept;
    logic         launch;
    logic         misalign_hit;

    logic [n-1:0] pc_d;
    logic         req_d;
    logic [n-1:0] addr_d;
    logic [n-1:0] instr_d;
    logic [n-1:0] instr_pc_d;
    logic         valid_d;
`ifdef FETCH_MISALIGN_CHK_EN
    logic         misalign_d;
`endif

    fetch_pc_gen #(
        .n (n)
    ) u_pc_gen (
        .pc      (pc),
        .pc_sel  (pc_sel),
        .target  (target),
        .next_pc (pc_next)
    );

    // Decode takes the held entry; this is the only moment pc_sel/target matter.
    assign accept = (state == HOLD) && instr_ready;

    // A new fetch starts either out of reset or right after an accept.
    assign launch = (state == IDLE) || accept;

    // Address of the fetch being launched: the reset PC, or the selected next PC.
    assign fetch_pc = (state == IDLE) ? pc : pc_next;

`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign_hit = launch && (fetch_pc[1:0] != 2'b00);
`else
    assign misalign_hit = 1'b0;
`endif

    // State register: reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one request outstanding, then hold until decode accepts.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // block leaves it unassigned and no latch is inferred.
        next_state = state;
        unique case (state)
            IDLE: next_state = misalign_hit ? HOLD : REQ;
            REQ:  if (imem_gnt)    next_state = WAIT;
            WAIT: if (imem_rvalid) next_state = HOLD;
            HOLD: if (instr_ready) next_state = misalign_hit ? HOLD : REQ;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: next values of the PC and of every registered output.
    always_comb begin
        pc_d       = pc;
        req_d      = imem_req;
        addr_d     = imem_addr;
        instr_d    = instr;
        instr_pc_d = instr_pc;
        valid_d    = instr_valid;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_d = instr_misalign;
`endif

        if (accept) begin
            pc_d    = pc_next;
            valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_d = 1'b0;
`endif
        end

        if (launch) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (misalign_hit) begin
                // No request for a misaligned PC; hand decode a flagged NOP instead.
                req_d      = 1'b0;
                instr_d    = n'(NOP_INSTR);
                instr_pc_d = fetch_pc;
                valid_d    = 1'b1;
                misalign_d = 1'b1;
            end else begin
                req_d  = 1'b1;
                addr_d = fetch_pc;
            end
`else
            req_d  = 1'b1;
            addr_d = fetch_pc & ADDR_MASK;
`endif
        end

        // Request is withdrawn as soon as memory accepts it.
        if ((state == REQ) && imem_gnt) begin
            req_d = 1'b0;
        end

        // Read data is captured only while waiting for it; stray rvalid is dropped.
        if ((state == WAIT) && imem_rvalid) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc;
            valid_d    = 1'b1;
        end
    end

    // PC and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= n'(NOP_INSTR);
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            instr_misalign <= 1'b0;
`endif
        end else begin
            pc          <= pc_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
            instr_valid <= valid_d;
`ifdef FETCH_MISALIGN_CHK_EN
            instr_misalign <= misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. The bench plays instruction memory and
// decode, and predicts fetch addresses and presented words from a
// transaction-level model of the PC sequence.
module tb_instr_fetch;
    import klp32_fetch_pkg::*;

    localparam int          N        = 32;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [N-1:0]  imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [N-1:0]  imem_rdata;
    logic [N-1:0]  instr;
    logic [N-1:0]  instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          pc_sel;
    logic [N-1:0]  target;
`ifdef FETCH_MISALIGN_CHK_EN
    logic          instr_misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state: PC of the next instruction the stage should fetch.
    logic [31:0] exp_pc;

    instr_fetch #(
        .n        (N),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_sel      (pc_sel),
        .target      (target)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .instr_misalign (instr_misalign)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Address the memory should see for a given PC.
    function automatic logic [31:0] addr_of(input logic [31:0] p);
        return p & 32'hFFFF_FFFC;
    endfunction

    // Random target; kept word-aligned when the misalign trap is built in.
    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    // Wait (bounded) for a request to appear.
    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (imem_req) break;
            @(negedge clk);
        end
        check(tag, 32'(imem_req), 32'd1);
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    // A misaligned PC must come back as a flagged NOP without any request.
    task automatic check_misalign_entry();
        check("mis_valid", 32'(instr_valid), 32'd1);
        check("mis_flag", 32'(instr_misalign), 32'd1);
        check("mis_instr", instr, NOP_INSTR);
        check("mis_pc", instr_pc, exp_pc);
        check("mis_no_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("mis_still_no_req", 32'(imem_req), 32'd0);
        instr_ready = 1'b1;
        pc_sel      = 1'b1;
        target      = 32'h0000_0200;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_sel      = 1'b0;
        exp_pc      = 32'h0000_0200;
        check("mis_cleared", 32'(instr_misalign), 32'd0);
        check("mis_next_req", 32'(imem_req), 32'd1);
    endtask
`endif

    // One full instruction transaction with the given memory/decode timing.
    task automatic fetch_one(input int gnt_dly, input int rv_dly, input logic [31:0] word,
                             input int rdy_dly, input logic sel, input logic [31:0] tgt,
                             input bit spur);
        logic [31:0] a0;
        wait_req("req_seen");
        check("req_addr", imem_addr, addr_of(exp_pc));
        a0 = imem_addr;
        for (int i = 0; i < gnt_dly; i++) begin
            imem_rvalid = spur && (i == 0);
            imem_rdata  = 32'hDEAD_BEEF;
            pc_sel      = 1'($urandom_range(1));
            target      = $urandom;
            @(negedge clk);
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_stable", imem_addr, a0);
            check("no_valid_in_req", 32'(instr_valid), 32'd0);
        end
        // gnt, optionally together with a stray rvalid that must be ignored
        imem_gnt    = 1'b1;
        imem_rvalid = spur;
        imem_rdata  = 32'hBAD0_0001;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        check("req_drop_after_gnt", 32'(imem_req), 32'd0);
        check("no_valid_after_gnt", 32'(instr_valid), 32'd0);
        for (int i = 0; i < rv_dly; i++) begin
            @(negedge clk);
            check("wait_no_req", 32'(imem_req), 32'd0);
            check("wait_no_valid", 32'(instr_valid), 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check("valid_latency", 32'(instr_valid), 32'd1);
        check("instr_word", instr, word);
        check("instr_pc", instr_pc, exp_pc);
        check("hold_no_req", 32'(imem_req), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
        check("no_misalign", 32'(instr_misalign), 32'd0);
`endif
        for (int i = 0; i < rdy_dly; i++) begin
            instr_ready = 1'b0;
            pc_sel      = 1'($urandom_range(1));
            target      = $urandom;
            imem_rvalid = 1'($urandom_range(1));
            imem_rdata  = $urandom;
            @(negedge clk);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, word);
            check("stall_pc", instr_pc, exp_pc);
            check("stall_no_req", 32'(imem_req), 32'd0);
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        pc_sel      = sel;
        target      = tgt;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_sel      = 1'($urandom_range(1));
        target      = $urandom;
        exp_pc      = sel ? (tgt & 32'hFFFF_FFFE) : (exp_pc + 32'd4);
`ifdef FETCH_MISALIGN_CHK_EN
        if (exp_pc[1:0] != 2'b00) begin
            check_misalign_entry();
        end else
`endif
        begin
            check("accept_clears_valid", 32'(instr_valid), 32'd0);
            check("back_to_back_req", 32'(imem_req), 32'd1);
        end
    endtask

    initial begin
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        pc_sel      = 1'b0;
        target      = '0;
        exp_pc      = RST_PC;

        repeat (3) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_instr_pc", instr_pc, RST_PC);
        check("rst_valid", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Immediate grant, next-cycle data, decode then stalls five cycles.
        fetch_one(0, 0, 32'h0000_0033, 5, 1'b0, 32'h0, 1'b0);
        // Branch to 0x101 must fetch from 0x100.
        fetch_one(0, 0, $urandom, 0, 1'b1, 32'h0000_0101, 1'b0);
        // Grant delayed three cycles with stray rvalid in REQ.
        fetch_one(3, 1, $urandom, 1, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int k = 0; k < 30; k++) begin
            fetch_one(int'($urandom_range(3)), int'($urandom_range(2)), $urandom,
                      int'($urandom_range(3)), ($urandom_range(3) == 0),
                      rand_target(), bit'($urandom_range(1)));
        end

        // Sequential wrap at the top of the address space.
        fetch_one(0, 0, $urandom, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        fetch_one(1, 0, $urandom, 0, 1'b0, 32'h0, 1'b0);
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Target 6: misaligned PC handling.
        fetch_one(0, 0, $urandom, 0, 1'b1, 32'h0000_0006, 1'b0);
        fetch_one(0, 0, $urandom, 0, 1'b0, 32'h0, 1'b0);

        // Reset while waiting for read data; late rvalid must be discarded.
        wait_req("rst_req_seen");
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        rst      = 1'b1;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_addr", imem_addr, RST_PC);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_instr", instr, NOP_INSTR);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = RST_PC;
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hC0DE_0BAD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("late_rvalid_dropped", 32'(instr_valid), 32'd0);
        check("late_rvalid_req", 32'(imem_req), 32'd1);
        check("refetch_reset_pc", imem_addr, RST_PC);
        fetch_one(0, 0, 32'h0000_0093, 0, 1'b0, 32'h0, 1'b0);
        fetch_one(2, 2, $urandom, 2, 1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
